// File: rtl/digit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : digit_scanner
// Description : Digit multiplexer for the 4-digit seven-segment display.
//               Rotates a one-hot digit select (MSB digit first) every
//               2^DIV_WIDTH clocks and drives registered active-low anodes.
//               Each slot starts with DEAD_CYCLES dark cycles, so the
//               downstream nibble selector, which registers its nibble one
//               cycle after a select change, settles before the anode
//               lights. This prevents ghosting.
//
// Ports       : clk         in   1  system clock
//               rst_n       in   1  asynchronous active-low reset
//               en          in   1  scan enable; low blanks and freezes
//               blank_mask  in   4  bit i set -> anode of select bit i off
//               brightness  in   4  PWM duty (only with DIGIT_SCANNER_PWM_EN)
//               select      out  4  one-hot digit select
//               digit_an    out  4  registered active-low anode drives
//               digit_tick  out  1  pulse in the first cycle of each slot
//
// Options     : DIGIT_SCANNER_PWM_EN - adds the brightness port; in the lit
//               part of a slot the anode is only driven while the top four
//               counter bits are <= brightness.
//
// Revision    : 1.0 - initial release
// ============================================================================

module digit_scanner #(
    parameter int DIV_WIDTH   = 16,  // slot length is 2^DIV_WIDTH clocks, >= 4
    parameter int DEAD_CYCLES = 4    // dark cycles per slot, >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] blank_mask,
`ifdef DIGIT_SCANNER_PWM_EN
    input  logic [3:0] brightness,
`endif
    output logic [3:0] select,
    output logic [3:0] digit_an,
    output logic       digit_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_dead = 2'd1;
    localparam logic [1:0] c_st_lit  = 2'd2;

    localparam logic [DIV_WIDTH-1:0] c_cnt_one  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] c_cnt_max  = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] c_dead_cnt = DIV_WIDTH'(DEAD_CYCLES);

    localparam logic [3:0] c_sel_first = 4'b1000;
    localparam logic [3:0] c_an_off    = 4'b1111;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]           select_q, select_d;
    logic [3:0]           digit_an_q, digit_an_d;
    logic                 digit_tick_q, digit_tick_d;

    logic [1:0]           state;
    logic                 slot_last;
    logic                 active_blanked;
    logic                 pwm_on;

    // ------------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------------
    assign slot_last = (div_cnt_q == c_cnt_max);

    // State is a pure function of en and the slot position; there is no
    // separate state register to keep consistent with the counter.
    always_comb begin
        state = c_st_lit;
        if (!en) begin
            state = c_st_idle;
        end else if (div_cnt_q < c_dead_cnt) begin
            state = c_st_dead;
        end
    end

    always_comb begin
        div_cnt_d    = '0;
        select_d     = select_q;
        digit_tick_d = 1'b0;
        if (en) begin
            div_cnt_d = div_cnt_q + c_cnt_one;
            if (slot_last) begin
                // Rotate right; a one-hot value stays one-hot.
                select_d     = {select_q[0], select_q[3:1]};
                digit_tick_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Anode drive
    // ------------------------------------------------------------------------
    // select is one-hot, so the AND picks exactly the active digit's mask bit.
    assign active_blanked = |(blank_mask & select_q);

`ifdef DIGIT_SCANNER_PWM_EN
    assign pwm_on = (div_cnt_q[DIV_WIDTH-1 -: 4] <= brightness);
`else
    assign pwm_on = 1'b1;
`endif

    // Registered from pre-edge values: in the first cycle of a new slot the
    // anode still shows the old digit, and it goes dark on the same edge the
    // downstream nibble register picks up the new digit's value.
    always_comb begin
        digit_an_d = c_an_off;
        if ((state == c_st_lit) && !active_blanked && pwm_on) begin
            digit_an_d = ~select_q;
        end
    end

    // ------------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            select_q     <= c_sel_first;
            digit_an_q   <= c_an_off;
            digit_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            select_q     <= select_d;
            digit_an_q   <= digit_an_d;
            digit_tick_q <= digit_tick_d;
        end
    end

    assign select     = select_q;
    assign digit_an   = digit_an_q;
    assign digit_tick = digit_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scanner
// Description : Self-checking bench for digit_scanner with 16-cycle slots
//               (DIV_WIDTH = 4, DEAD_CYCLES = 2). A slot/digit-index model
//               predicts select, digit_an and digit_tick every cycle, a
//               model nibble selector (data 16'h1234) checks that no lit
//               anode shows a stale nibble, and directed literal checks pin
//               the model. Define DIGIT_SCANNER_PWM_EN to add the PWM case.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_digit_scanner;

    localparam int DW   = 4;
    localparam int DEAD = 2;
    localparam int SLOT = 16;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic [3:0] blank_mask = 4'b0000;
`ifdef DIGIT_SCANNER_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif
    logic [3:0] select;
    logic [3:0] digit_an;
    logic       digit_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_scanner #(
        .DIV_WIDTH   (DW),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .blank_mask (blank_mask),
`ifdef DIGIT_SCANNER_PWM_EN
        .brightness (brightness),
`endif
        .select     (select),
        .digit_an   (digit_an),
        .digit_tick (digit_tick)
    );

    // ------------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------------
    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b1000;
        return v >> i;
    endfunction

    // ------------------------------------------------------------------------
    // Model: slot position 0..SLOT-1 and digit index 0..3 (0 = leftmost)
    // ------------------------------------------------------------------------
    int         m_pos  = 0;
    int         m_idx  = 0;
    logic [3:0] m_an   = 4'hF;
    logic       m_tick = 1'b0;

    function automatic bit model_lit(input int pos);
        bit lit;
        lit = en && (pos >= DEAD);
`ifdef DIGIT_SCANNER_PWM_EN
        if ((pos >> (DW - 4)) > int'(brightness)) lit = 1'b0;
`endif
        return lit;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  <= 0;
            m_idx  <= 0;
            m_an   <= 4'hF;
            m_tick <= 1'b0;
        end else begin
            m_an   <= (model_lit(m_pos) && !blank_mask[3 - m_idx]) ? ~onehot(m_idx) : 4'hF;
            m_tick <= en && (m_pos == SLOT - 1);
            if (en) begin
                if (m_pos == SLOT - 1) begin
                    m_pos <= 0;
                    m_idx <= (m_idx + 1) % 4;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end else begin
                m_pos <= 0;
            end
        end
    end

    // Downstream nibble selector: registers the selected nibble.
    logic [15:0] data = 16'h1234;
    logic [3:0]  nib  = 4'h0;

    always @(posedge clk) begin
        case (select)
            4'b1000: nib <= data[15:12];
            4'b0100: nib <= data[11:8];
            4'b0010: nib <= data[7:4];
            4'b0001: nib <= data[3:0];
            default: nib <= 4'h0;
        endcase
    end

    function automatic logic [3:0] exp_nib(input logic [3:0] an);
        case (an)
            4'b0111: return 4'h1;
            4'b1011: return 4'h2;
            4'b1101: return 4'h3;
            4'b1110: return 4'h4;
            default: return 4'hF;
        endcase
    endfunction

    // Per-cycle compare, 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        check4("select", select, onehot(m_idx));
        check4("digit_an", digit_an, m_an);
        check1("digit_tick", digit_tick, m_tick);
        if (digit_an != 4'hF) begin
            check4("lit_nibble", nib, exp_nib(digit_an));
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus and literal checks (inputs change on falling edges)
    // ------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] rec_an   [1:82];
    logic [3:0] rec_sel  [1:82];
    logic       rec_tick [1:82];

    initial begin
        int         p;
        int         len;
        int         bad;
        int         cnt;
        logic [3:0] pat;

        // Power-on reset
        rst_n = 1'b0;
        en    = 1'b0;
        step(2);
        check4("por_select", select, 4'b1000);
        check4("por_an", digit_an, 4'b1111);
        check1("por_tick", digit_tick, 1'b0);

        // Free-running scan: k counts falling edges after release; div_cnt = k % 16
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            rec_an[k]   = digit_an;
            rec_sel[k]  = select;
            rec_tick[k] = digit_tick;
        end
        check4("k2_dark", rec_an[2], 4'b1111);
        check4("k3_first_lit", rec_an[3], 4'b0111);
        check4("k15_sel", rec_sel[15], 4'b1000);
        check4("k16_sel", rec_sel[16], 4'b0100);
        check1("k16_tick", rec_tick[16], 1'b1);
        check4("k16_old_digit", rec_an[16], 4'b0111);
        check4("k19_lit", rec_an[19], 4'b1011);
        check4("k32_sel", rec_sel[32], 4'b0010);
        check4("k48_sel", rec_sel[48], 4'b0001);
        check4("k64_sel", rec_sel[64], 4'b1000);
        bad = 0;
        for (int k = 1; k <= 80; k++) begin
            if (rec_tick[k] != ((k % 16) == 0)) bad++;
        end
        check_int("tick_positions", bad, 0);
        p = 3;
        for (int r = 0; r < 5; r++) begin
            pat = ~onehot(r % 4);
            len = 0;
            while (p <= 82 && rec_an[p] == pat) begin
                len++;
                p++;
            end
            check_int($sformatf("low_run%0d", r), len, 14);
            if (r < 4) begin
                len = 0;
                while (p <= 82 && rec_an[p] == 4'hF) begin
                    len++;
                    p++;
                end
                check_int($sformatf("dark_run%0d", r), len, 2);
            end
        end

        // Asynchronous reset mid-slot while 1011 is lit
        step(1);
        check4("pre_reset_lit", digit_an, 4'b1011);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_rst_select", select, 4'b1000);
        check4("async_rst_an", digit_an, 4'b1111);
        check1("async_rst_tick", digit_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;                   // kp = 0
        step(2);
        check4("rel_kp2_dark", digit_an, 4'b1111);
        step(1);
        check4("rel_kp3_lit", digit_an, 4'b0111);
        step(13);                       // kp = 16, select 0100 slot begins

        // Blank digit 1 (select bit 2)
        blank_mask = 4'b0100;
        cnt = 0;
        for (int kp = 17; kp <= 34; kp++) begin
            @(negedge clk);
            if (digit_an != 4'hF) cnt++;
            if (kp == 32) begin
                check4("blank_kp32_sel", select, 4'b0010);
                check1("blank_kp32_tick", digit_tick, 1'b1);
            end
        end
        check_int("blank_slot_lit_cycles", cnt, 0);
        step(1);                        // kp = 35
        check4("blank_next_digit", digit_an, 4'b1101);
        step(5);                        // kp = 40
        blank_mask = 4'b0000;

        // Drop en at div_cnt = 9 of the select = 0010 slot
        step(1);                        // kp = 41
        check4("pre_drop_lit", digit_an, 4'b1101);
        en = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step(1);
            check4($sformatf("en_low%0d_an", j), digit_an, 4'b1111);
            check4($sformatf("en_low%0d_sel", j), select, 4'b0010);
            check1($sformatf("en_low%0d_tick", j), digit_tick, 1'b0);
        end
        en = 1'b1;                      // m = 0
        step(2);
        check4("en_rise_m2_dark", digit_an, 4'b1111);
        step(1);
        check4("en_rise_m3_lit", digit_an, 4'b1101);
        step(12);
        check4("en_rise_m15_sel", select, 4'b0010);
        step(1);
        check4("en_rise_m16_sel", select, 4'b0001);
        check1("en_rise_m16_tick", digit_tick, 1'b1);

`ifdef DIGIT_SCANNER_PWM_EN
        // brightness = 7: lit only for div_cnt 3..8 of the select = 0001 slot
        brightness = 4'd7;
        bad = 0;
        cnt = 0;
        for (int m = 17; m <= 32; m++) begin
            @(negedge clk);
            if (digit_an != 4'hF) cnt++;
            if ((digit_an == 4'b1110) != (m >= 19 && m <= 24)) bad++;
        end
        check_int("pwm7_lit_cycles", cnt, 6);
        check_int("pwm7_positions", bad, 0);
        brightness = 4'd15;
`endif

        step(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
